// File: rtl/nios2_sensor_pio.sv
// nios2_sensor_pio
//
// Multi-channel Avalon-MM input port for sensor readings. NUM_CH parallel
// sensor buses are brought into the clk domain through two-flop
// synchronisers. They are then sampled at a programmable rate into readable
// DATA registers. An upward crossing of a shared threshold sets a sticky
// per-channel STATUS flag, and the masked OR of those flags drives a
// registered level interrupt.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    Avalon word address (4 bits)
//   read       Avalon read strobe (reads have no side effects, so it is unused)
//   write      Avalon write strobe
//   writedata  Avalon write data (32 bits)
//   readdata   registered read data, valid one cycle after address is presented
//   in_port    NUM_CH*DATA_W sensor inputs, channel c at [c*DATA_W +: DATA_W],
//              asynchronous to clk
//   irq        registered level interrupt, |(STATUS & IRQ_MASK)
//
// Register map (word address):
//   0..NUM_CH-1 DATA[c] (ro), 8 STATUS (w1c), 9 IRQ_MASK, 10 THRESH,
//   11 SAMPLE_DIV, 12 CONTROL {HOLD, ENABLE}; everything else reads 0.
//
// Bus handshake: Avalon-MM with fixed timing and no waitrequest. A write
// takes effect on the edge where write is high. readdata always shows the
// register selected by address on the previous edge, whether or not read
// is asserted.

module nios2_sensor_pio #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic                     irq
);

    localparam logic [3:0] ADDR_STATUS  = 4'd8;
    localparam logic [3:0] ADDR_MASK    = 4'd9;
    localparam logic [3:0] ADDR_THRESH  = 4'd10;
    localparam logic [3:0] ADDR_DIV     = 4'd11;
    localparam logic [3:0] ADDR_CONTROL = 4'd12;

    logic [NUM_CH*DATA_W-1:0] sync1;
    logic [NUM_CH*DATA_W-1:0] sync2;
    logic [DATA_W-1:0]        data_q [NUM_CH];
    logic [NUM_CH-1:0]        status;
    logic [NUM_CH-1:0]        irq_mask;
    logic [DATA_W-1:0]        thresh;
    logic [15:0]              sample_div;
    logic                     enable;
    logic                     hold;
    logic [15:0]              cnt;

    logic                     strobe;
    logic                     capture;
    logic [NUM_CH-1:0]        status_set;
    logic [NUM_CH-1:0]        status_clr;
    logic [31:0]              rd_mux;

    logic wr_status, wr_mask, wr_thresh, wr_div, wr_control;

    // Reads have no side effects, and only the low bits of writedata land
    // in registers.
    logic unused_ok;
    assign unused_ok = ^{read, writedata};

    assign wr_status  = write && (address == ADDR_STATUS);
    assign wr_mask    = write && (address == ADDR_MASK);
    assign wr_thresh  = write && (address == ADDR_THRESH);
    assign wr_div     = write && (address == ADDR_DIV);
    assign wr_control = write && (address == ADDR_CONTROL);

    // The strobe comes straight from the current counter state. A reset in
    // the same cycle overrides every register update, so no sample is taken.
    assign strobe  = enable && (cnt == 16'd0);
    assign capture = strobe && !hold;

    always_comb begin
        status_set = '0;
        status_clr = '0;
        if (wr_status) begin
            status_clr = writedata[NUM_CH-1:0];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (capture && (data_q[c] <= thresh) &&
                (sync2[c*DATA_W +: DATA_W] > thresh)) begin
                status_set[c] = 1'b1;
            end
        end
    end

    // Two-flop synchroniser, always running
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Sample counter. A write to SAMPLE_DIV or CONTROL restarts the period
    // from the (new) SAMPLE_DIV value. While disabled, the counter parks at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (wr_div) begin
            cnt <= writedata[15:0];
        end else if (wr_control) begin
            cnt <= sample_div;
        end else if (!enable) begin
            cnt <= 16'd0;
        end else if (cnt == 16'd0) begin
            cnt <= sample_div;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask   <= '0;
            thresh     <= '1;
            sample_div <= 16'd0;
            enable     <= 1'b0;
            hold       <= 1'b0;
        end else begin
            if (wr_mask)    irq_mask   <= writedata[NUM_CH-1:0];
            if (wr_thresh)  thresh     <= writedata[DATA_W-1:0];
            if (wr_div)     sample_div <= writedata[15:0];
            if (wr_control) begin
                enable <= writedata[0];
                hold   <= writedata[1];
            end
        end
    end

    // Data capture and sticky flags. The set term is ORed in after the
    // clear, so a crossing wins over a same-cycle write-1-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c] <= '0;
            end
            status <= '0;
        end else begin
            if (capture) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    data_q[c] <= sync2[c*DATA_W +: DATA_W];
                end
            end
            status <= (status & ~status_clr) | status_set;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address == 4'(c)) begin
                rd_mux = 32'(data_q[c]);
            end
        end
        case (address)
            ADDR_STATUS:  rd_mux = 32'(status);
            ADDR_MASK:    rd_mux = 32'(irq_mask);
            ADDR_THRESH:  rd_mux = 32'(thresh);
            ADDR_DIV:     rd_mux = {16'd0, sample_div};
            ADDR_CONTROL: rd_mux = {30'd0, hold, enable};
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(status & irq_mask);
        end
    end

endmodule

// File: tb/tb_nios2_sensor_pio.sv
// Self-checking bench for nios2_sensor_pio (NUM_CH=4, DATA_W=16).
// Inputs are driven 1 ns after a rising edge, and outputs are sampled 1 ns
// after the following rising edge.

module tb_nios2_sensor_pio;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;

    logic                     clk;
    logic                     reset;
    logic [3:0]               address;
    logic                     read;
    logic                     write;
    logic [31:0]              writedata;
    logic [31:0]              readdata;
    logic [NUM_CH*DATA_W-1:0] in_port;
    logic                     irq;

    int n_tests;
    int n_fail;

    nios2_sensor_pio #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        do_write;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic set_ch(input int c, input logic [DATA_W-1:0] v);
        in_port[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic add_vec(input logic [3:0] a, input logic w, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.do_write = w; v.wdata = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] prev;
        int          last_chg;
        int          n_chg;

        n_tests = 0;
        n_fail  = 0;

        // Reset-value reads over the whole address space
        for (int a = 0; a < 16; a++) begin
            add_vec(4'(a), 1'b0, 32'd0, (a == 10) ? 32'h0000_FFFF : 32'd0);
        end
        // Write-then-readback: field widths, read-only and unmapped addresses
        add_vec(4'd9,  1'b1, 32'hFFFF_FFFF, 32'h0000_000F);
        add_vec(4'd10, 1'b1, 32'hABCD_1234, 32'h0000_1234);
        add_vec(4'd11, 1'b1, 32'h1234_5678, 32'h0000_5678);
        add_vec(4'd12, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);
        add_vec(4'd13, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
        add_vec(4'd0,  1'b1, 32'h0000_FFFF, 32'h0000_0000);
        add_vec(4'd8,  1'b1, 32'h0000_000F, 32'h0000_0000);

        // Reset block
        reset     = 1'b1;
        address   = 4'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        in_port   = '0;
        tick(3);
        check("irq_during_reset", {31'd0, irq}, 32'd0);
        check("readdata_during_reset", readdata, 32'd0);
        reset = 1'b0;
        tick(1);
        check("irq_after_reset", {31'd0, irq}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_write) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), r, vecs[i].exp);
        end
        check("irq_no_status", {31'd0, irq}, 32'd0);

        // Restore defaults and enable with SAMPLE_DIV=0
        wr(4'd9, 32'd0);
        wr(4'd10, 32'h0000_FFFF);
        wr(4'd11, 32'd0);
        wr(4'd12, 32'd1);
        tick(4);

        // Two-edge capture latency on channel 2
        address = 4'd2;
        tick(2);
        set_ch(2, 16'h1234);
        tick(3);
        check("ch2_before_capture", readdata, 32'd0);
        tick(1);
        check("ch2_captured", readdata, 32'h0000_1234);

        // SAMPLE_DIV=9: one capture per 10 cycles on a channel changing every cycle
        wr(4'd11, 32'd9);
        address = 4'd0;
        tick(1);
        prev     = readdata;
        last_chg = -1;
        n_chg    = 0;
        for (int i = 0; i < 45; i++) begin
            set_ch(0, 16'(16'h0100 + i));
            tick(1);
            if (readdata !== prev) begin
                check($sformatf("div9_value_at_%0d", i), readdata, 32'(16'h0100 + i - 3));
                if (last_chg >= 0) check($sformatf("div9_spacing_at_%0d", i), 32'(i - last_chg), 32'd10);
                last_chg = i;
                n_chg++;
            end
            prev = readdata;
        end
        check("div9_change_count", {31'd0, n_chg >= 4}, 32'd1);
        wr(4'd11, 32'd0);

        // Threshold crossing, sticky flag, irq latency, W1C
        wr(4'd10, 32'h0000_0100);
        wr(4'd9, 32'h0000_0001);
        set_ch(0, 16'h00FF);
        tick(5);
        wr(4'd8, 32'h0000_000F);
        tick(2);
        check("irq_before_cross", {31'd0, irq}, 32'd0);
        set_ch(0, 16'h0101);
        tick(3);
        check("irq_one_before", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_after_cross", {31'd0, irq}, 32'd1);
        rd(4'd8, r);
        check("status_cross", r, 32'h1);
        set_ch(0, 16'h0050);
        tick(5);
        set_ch(0, 16'h0200);
        tick(5);
        rd(4'd8, r);
        check("status_sticky", r, 32'h1);
        wr(4'd8, 32'h1);
        check("irq_on_clear_edge", {31'd0, irq}, 32'd1);
        tick(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd(4'd8, r);
        check("status_cleared", r, 32'h0);
        set_ch(0, 16'h0050);
        tick(5);
        set_ch(0, 16'h0180);
        tick(5);
        rd(4'd8, r);
        check("status_recross", r, 32'h1);
        check("irq_recross", {31'd0, irq}, 32'd1);

        // Crossing strobe on the same edge as a W1C of that bit
        set_ch(0, 16'h0050);
        tick(5);
        wr(4'd8, 32'h1);
        tick(2);
        rd(4'd8, r);
        check("status_pre_coincide", r, 32'h0);
        set_ch(0, 16'h0180);
        tick(2);
        address   = 4'd8;
        writedata = 32'h1;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
        rd(4'd8, r);
        check("status_set_wins", r, 32'h1);
        wr(4'd8, 32'h1);
        tick(1);
        rd(4'd8, r);
        check("status_clear_again", r, 32'h0);

        // HOLD freezes DATA and STATUS
        wr(4'd12, 32'd3);
        set_ch(1, 16'h0300);
        tick(6);
        rd(4'd1, r);
        check("hold_data1", r, 32'd0);
        rd(4'd8, r);
        check("hold_status", r, 32'd0);
        wr(4'd12, 32'd1);
        tick(4);
        rd(4'd1, r);
        check("release_data1", r, 32'h0000_0300);
        rd(4'd8, r);
        check("release_status", r, 32'h2);
        check("irq_masked_ch1", {31'd0, irq}, 32'd0);
        wr(4'd9, 32'h3);
        tick(2);
        check("irq_unmasked_ch1", {31'd0, irq}, 32'd1);

        // Reset mid-operation returns everything to reset values
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("irq_after_midreset", {31'd0, irq}, 32'd0);
        check("readdata_after_midreset", readdata, 32'd0);
        set_ch(0, 16'h0077);
        tick(6);
        rd(4'd0, r);
        check("data0_disabled", r, 32'd0);
        rd(4'd1, r);
        check("data1_after_reset", r, 32'd0);
        rd(4'd8, r);
        check("status_after_reset", r, 32'd0);
        rd(4'd10, r);
        check("thresh_after_reset", r, 32'h0000_FFFF);
        rd(4'd12, r);
        check("control_after_reset", r, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
